alsu_pipe: RTL and testbench

Parametrised, pipelined successor of the 3-bit ALSU. Operand width is generic, and input and output stages are qualified by a valid strobe. Invalid-operation handling is sticky, with a timed LED blink pattern. Sits between the board switch/UART front-end and the LED/7-seg display path.

---
 rtl/alsu_pipe_if.sv | 34 +++
 rtl/alsu_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_alsu_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alsu_pipe_if.sv
// Operand/control bus from the switch/UART front-end and result/indicator bus
// toward the LED/7-seg display path.
interface alsu_pipe_if #(
    parameter int WIDTH     = 4,
    parameter int LED_WIDTH = 16
);
    logic                 in_valid;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2:0]           opcode;
    logic                 cin;
    logic                 serial_in;
    logic                 direction;
    logic                 red_op_A;
    logic                 red_op_B;
    logic                 bypass_A;
    logic                 bypass_B;
    logic [2*WIDTH-1:0]   out;
    logic                 out_valid;
    logic                 err;
    logic [LED_WIDTH-1:0] leds;

    modport master (
        output in_valid, A, B, opcode, cin, serial_in, direction,
               red_op_A, red_op_B, bypass_A, bypass_B,
        input  out, out_valid, err, leds
    );

    modport slave (
        input  in_valid, A, B, opcode, cin, serial_in, direction,
               red_op_A, red_op_B, bypass_A, bypass_B,
        output out, out_valid, err, leds
    );
endinterface

// File: rtl/alsu_pipe.sv
// Two-stage pipelined ALSU: stage 1 registers qualified operands, stage 2
// computes the result and tracks a sticky error state with a blinking LED bank.
module alsu_pipe #(
    parameter int    WIDTH          = 4,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    LED_WIDTH      = 16,
    parameter int    BLINK_DIV      = 4
) (
    input  logic       clk,
    input  logic       rst,
    alsu_pipe_if.slave bus
);
    localparam int OUT_W = 2 * WIDTH;
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
    localparam bit PRIO_B = (INPUT_PRIORITY == "B");
    localparam bit FA_ON  = (FULL_ADDER == "ON");

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_opcode;
    logic             r_cin;
    logic             r_serial;
    logic             r_dir;
    logic             r_red_a;
    logic             r_red_b;
    logic             r_byp_a;
    logic             r_byp_b;

    logic [OUT_W-1:0]     r_out;
    logic                 r_out_valid;
    logic                 r_err;
    logic [LED_WIDTH-1:0] r_leds;
    logic                 r_err_state;
    logic [CNT_W-1:0]     r_cnt;

    logic [WIDTH-1:0]     w_pri_op;
    logic [WIDTH-1:0]     w_byp_op;
    logic [WIDTH-1:0]     w_red_op;
    logic                 w_red_any;
    logic                 w_invalid;
    logic [WIDTH:0]       w_sum;
    logic [OUT_W-1:0]     w_prod;
    logic [OUT_W-1:0]     w_result;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [LED_WIDTH-1:0] w_leds_next;

    // Stage 1: capture operands and controls on qualified cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_opcode   <= 3'd0;
            r_cin      <= 1'b0;
            r_serial   <= 1'b0;
            r_dir      <= 1'b0;
            r_red_a    <= 1'b0;
            r_red_b    <= 1'b0;
            r_byp_a    <= 1'b0;
            r_byp_b    <= 1'b0;
        end else begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_a      <= bus.A;
                r_b      <= bus.B;
                r_opcode <= bus.opcode;
                r_cin    <= bus.cin;
                r_serial <= bus.serial_in;
                r_dir    <= bus.direction;
                r_red_a  <= bus.red_op_A;
                r_red_b  <= bus.red_op_B;
                r_byp_a  <= bus.bypass_A;
                r_byp_b  <= bus.bypass_B;
            end
        end
    end

    assign w_pri_op  = PRIO_B ? r_b : r_a;
    assign w_red_any = r_red_a | r_red_b;
    assign w_invalid = (r_opcode == 3'd6) || (r_opcode == 3'd7) ||
                       (w_red_any && (r_opcode > 3'd1));
    assign w_sum     = {1'b0, r_a} + {1'b0, r_b} +
                       {{WIDTH{1'b0}}, (FA_ON ? r_cin : 1'b0)};
    assign w_prod    = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    // Resolve which operand a bypass or reduction refers to
    always_comb begin
        w_byp_op = r_b;
        w_red_op = r_b;
        if (r_byp_a && r_byp_b) begin
            w_byp_op = w_pri_op;
        end else if (r_byp_a) begin
            w_byp_op = r_a;
        end else begin
            w_byp_op = r_b;
        end
        if (r_red_a && r_red_b) begin
            w_red_op = w_pri_op;
        end else if (r_red_a) begin
            w_red_op = r_a;
        end else begin
            w_red_op = r_b;
        end
    end

    // Result of a valid op; shift/rotate act on the current output register
    always_comb begin
        w_result = '0;
        if (r_byp_a || r_byp_b) begin
            w_result = {{WIDTH{1'b0}}, w_byp_op};
        end else begin
            case (r_opcode)
                3'd0: begin
                    if (w_red_any) begin
                        w_result = {{(OUT_W-1){1'b0}}, &w_red_op};
                    end else begin
                        w_result = {{WIDTH{1'b0}}, r_a & r_b};
                    end
                end
                3'd1: begin
                    if (w_red_any) begin
                        w_result = {{(OUT_W-1){1'b0}}, ^w_red_op};
                    end else begin
                        w_result = {{WIDTH{1'b0}}, r_a ^ r_b};
                    end
                end
                3'd2: w_result = {{(WIDTH-1){1'b0}}, w_sum};
                3'd3: w_result = w_prod;
                3'd4: begin
                    if (r_dir) begin
                        w_result = {r_out[OUT_W-2:0], r_serial};
                    end else begin
                        w_result = {r_serial, r_out[OUT_W-1:1]};
                    end
                end
                3'd5: begin
                    if (r_dir) begin
                        w_result = {r_out[OUT_W-2:0], r_out[OUT_W-1]};
                    end else begin
                        w_result = {r_out[0], r_out[OUT_W-1:1]};
                    end
                end
                default: w_result = '0;
            endcase
        end
    end

    // Free-running blink step used whenever the error state persists
    always_comb begin
        w_cnt_next  = r_cnt;
        w_leds_next = r_leds;
        if (r_cnt == CNT_MAX) begin
            w_cnt_next  = '0;
            w_leds_next = ~r_leds;
        end else begin
            w_cnt_next  = r_cnt + CNT_W'(1);
            w_leds_next = r_leds;
        end
    end

    // Stage 2: result register, status strobes and sticky error indicator
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_leds      <= '0;
            r_err_state <= 1'b0;
            r_cnt       <= '0;
        end else if (r_s1_valid) begin
            r_out_valid <= 1'b1;
            if (w_invalid) begin
                r_out       <= '0;
                r_err       <= 1'b1;
                r_err_state <= 1'b1;
                if (!r_err_state) begin
                    r_leds <= '1;
                    r_cnt  <= '0;
                end else begin
                    r_leds <= w_leds_next;
                    r_cnt  <= w_cnt_next;
                end
            end else begin
                r_out       <= w_result;
                r_err       <= 1'b0;
                r_err_state <= 1'b0;
                r_leds      <= '0;
                r_cnt       <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            if (r_err_state) begin
                r_leds <= w_leds_next;
                r_cnt  <= w_cnt_next;
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.err       = r_err;
    assign bus.leds      = r_leds;
endmodule

// File: tb/tb_alsu_pipe.sv
// Bench for alsu_pipe: two instances (priority A / full adder, priority B / no
// carry-in) checked against an arithmetic reference model.
module tb_alsu_pipe;
    localparam int W  = 4;
    localparam int OW = 8;
    localparam int LW = 16;
    localparam int BD = 4;

    typedef struct {
        bit v;
        int a, b, opc, cin, sin, dir, ra, rb, ba, bb;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         iv, cin, sin, dir, ra, rb, ba, bb;
    logic [W-1:0] a, b;
    logic [2:0]   opc;

    alsu_pipe_if #(.WIDTH(W), .LED_WIDTH(LW)) ifa ();
    alsu_pipe_if #(.WIDTH(W), .LED_WIDTH(LW)) ifb ();

    assign ifa.in_valid = iv;  assign ifb.in_valid = iv;
    assign ifa.A = a;          assign ifb.A = a;
    assign ifa.B = b;          assign ifb.B = b;
    assign ifa.opcode = opc;   assign ifb.opcode = opc;
    assign ifa.cin = cin;      assign ifb.cin = cin;
    assign ifa.serial_in = sin; assign ifb.serial_in = sin;
    assign ifa.direction = dir; assign ifb.direction = dir;
    assign ifa.red_op_A = ra;  assign ifb.red_op_A = ra;
    assign ifa.red_op_B = rb;  assign ifb.red_op_B = rb;
    assign ifa.bypass_A = ba;  assign ifb.bypass_A = ba;
    assign ifa.bypass_B = bb;  assign ifb.bypass_B = bb;

    alsu_pipe #(.WIDTH(W), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"),
                .LED_WIDTH(LW), .BLINK_DIV(BD))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    alsu_pipe #(.WIDTH(W), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"),
                .LED_WIDTH(LW), .BLINK_DIV(BD))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state: index 0 models dut_a, index 1 models dut_b
    op_t          prev;
    logic [OW-1:0] e_out[2];
    logic          e_ov[2], e_err[2];
    logic [LW-1:0] e_leds[2];
    bit            m_est[2];
    int            m_n[2];

    function automatic logic [OW-1:0] ref_result(op_t o, int idx, logic [OW-1:0] cur);
        int r, sel, c;
        c = cur;
        if (o.ba != 0 || o.bb != 0) begin
            if (o.ba != 0 && o.bb != 0) r = (idx == 1) ? o.b : o.a;
            else r = (o.ba != 0) ? o.a : o.b;
            return OW'(r);
        end
        if (o.ra != 0 && o.rb != 0) sel = (idx == 1) ? o.b : o.a;
        else sel = (o.ra != 0) ? o.a : o.b;
        case (o.opc)
            0: r = (o.ra != 0 || o.rb != 0) ? ((sel == 15) ? 1 : 0) : (o.a & o.b);
            1: r = (o.ra != 0 || o.rb != 0) ? ($countones(sel) % 2) : (o.a ^ o.b);
            2: r = o.a + o.b + ((idx == 0) ? o.cin : 0);
            3: r = o.a * o.b;
            4: r = (o.dir != 0) ? ((c * 2 + o.sin) % 256) : (o.sin * 128 + c / 2);
            5: r = (o.dir != 0) ? ((c * 2) % 256 + c / 128) : ((c % 2) * 128 + c / 2);
            default: r = 0;
        endcase
        return OW'(r);
    endfunction

    function automatic bit is_invalid(op_t o);
        return (o.opc >= 6) || ((o.ra != 0 || o.rb != 0) && o.opc > 1);
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (prev.v) begin
                e_ov[i] = 1'b1;
                if (is_invalid(prev)) begin
                    e_out[i] = '0;
                    e_err[i] = 1'b1;
                    if (!m_est[i]) begin m_est[i] = 1'b1; m_n[i] = 0; end
                    else m_n[i]++;
                end else begin
                    e_out[i] = ref_result(prev, i, e_out[i]);
                    e_err[i] = 1'b0;
                    m_est[i] = 1'b0;
                end
            end else begin
                e_ov[i]  = 1'b0;
                e_err[i] = 1'b0;
                if (m_est[i]) m_n[i]++;
            end
            // Error LEDs start all-on and invert every BLINK_DIV edges
            e_leds[i] = (m_est[i] && ((m_n[i] / BD) % 2 == 0)) ? 16'hFFFF : 16'h0000;
        end
    endtask

    task automatic step();
        op_t cur;
        cur.v = iv; cur.a = a; cur.b = b; cur.opc = opc; cur.cin = cin;
        cur.sin = sin; cur.dir = dir; cur.ra = ra; cur.rb = rb; cur.ba = ba; cur.bb = bb;
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                e_out[i] = '0; e_ov[i] = 1'b0; e_err[i] = 1'b0;
                e_leds[i] = '0; m_est[i] = 1'b0; m_n[i] = 0;
            end
            prev.v = 1'b0;
        end else begin
            model_edge();
            prev = cur;
        end
        #1;
    endtask

    task automatic set_op(input int a_, b_, opc_, cin_, sin_, dir_, ra_, rb_, ba_, bb_);
        iv = 1'b1; a = W'(a_); b = W'(b_); opc = 3'(opc_); cin = 1'(cin_);
        sin = 1'(sin_); dir = 1'(dir_); ra = 1'(ra_); rb = 1'(rb_); ba = 1'(ba_); bb = 1'(bb_);
    endtask

    task automatic idle();
        iv = 1'b0;
    endtask

    function automatic logic [OW+LW+1:0] got(int idx);
        if (idx == 0) return {ifa.out, ifa.out_valid, ifa.err, ifa.leds};
        else return {ifb.out, ifb.out_valid, ifb.err, ifb.leds};
    endfunction

    function automatic logic [OW+LW+1:0] expv(int idx);
        return {e_out[idx], e_ov[idx], e_err[idx], e_leds[idx]};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        n_cmp++;
        if ({ifa.out, ifa.out_valid, ifa.err, ifa.leds} !== 26'h0) begin
            n_fail++; $display("FAIL reset_a got %h want 0", got(0));
        end
        n_cmp++;
        if ({ifb.out, ifb.out_valid, ifb.err, ifb.leds} !== 26'h0) begin
            n_fail++; $display("FAIL reset_b got %h want 0", got(1));
        end
        rst = 1'b1;
        idle();
        step();
    endtask

    task automatic test_add();
        set_op(15, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        step();
        idle();
        step();
        n_cmp++;
        if (ifa.out !== 8'h11 || ifa.out_valid !== 1'b1 || ifa.err !== 1'b0) begin
            n_fail++; $display("FAIL add_a got out=%h ov=%b err=%b want 11/1/0", ifa.out, ifa.out_valid, ifa.err);
        end
        n_cmp++;
        if (ifb.out !== 8'h10) begin
            n_fail++; $display("FAIL add_nocarry_b got %h want 10", ifb.out);
        end
        step();
        n_cmp++;
        if (ifa.out_valid !== 1'b0 || ifa.out !== 8'h11) begin
            n_fail++; $display("FAIL add_hold got out=%h ov=%b want 11/0", ifa.out, ifa.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        set_op(15, 15, 3, 0, 0, 0, 0, 0, 0, 0);
        step();
        set_op(0, 0, 4, 0, 1, 1, 0, 0, 0, 0);
        step();
        n_cmp++;
        if (ifa.out !== 8'hE1) begin n_fail++; $display("FAIL mul got %h want e1", ifa.out); end
        set_op(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        step();
        n_cmp++;
        if (ifa.out !== 8'hC3 || ifa.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL shift_left got %h ov=%b want c3/1", ifa.out, ifa.out_valid);
        end
        idle();
        step();
        n_cmp++;
        if (ifa.out !== 8'hE1 || ifb.out !== 8'hE1) begin
            n_fail++; $display("FAIL rotate_right got %h/%h want e1", ifa.out, ifb.out);
        end
    endtask

    task automatic test_reduction_priority();
        set_op(15, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step();
        idle();
        step();
        n_cmp++;
        if (ifa.out !== 8'h01) begin n_fail++; $display("FAIL red_prio_a got %h want 01", ifa.out); end
        n_cmp++;
        if (ifb.out !== 8'h00) begin n_fail++; $display("FAIL red_prio_b got %h want 00", ifb.out); end
    endtask

    task automatic test_invalid_blink();
        set_op(9, 3, 6, 0, 0, 0, 0, 0, 1, 0);
        step();
        idle();
        step();
        n_cmp++;
        if (ifa.out !== 8'h00 || ifa.err !== 1'b1 || ifa.out_valid !== 1'b1 || ifa.leds !== 16'hFFFF) begin
            n_fail++; $display("FAIL invalid_entry got out=%h err=%b ov=%b leds=%h", ifa.out, ifa.err, ifa.out_valid, ifa.leds);
        end
        for (int k = 1; k <= 9; k++) begin
            step();
            n_cmp++;
            if (got(0) !== expv(0) || got(1) !== expv(1)) begin
                n_fail++; $display("FAIL blink_k%0d got %h/%h want %h", k, got(0), got(1), expv(0));
            end
            if (k == 4) begin
                n_cmp++;
                if (ifa.leds !== 16'h0000 || ifa.err !== 1'b0) begin
                    n_fail++; $display("FAIL blink_toggle got leds=%h err=%b want 0000/0", ifa.leds, ifa.err);
                end
            end
        end
        set_op(5, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        idle();
        step();
        n_cmp++;
        if (ifa.out !== 8'h06 || ifa.leds !== 16'h0000 || ifa.err !== 1'b0) begin
            n_fail++; $display("FAIL err_clear got out=%h leds=%h err=%b want 06/0000/0", ifa.out, ifa.leds, ifa.err);
        end
    endtask

    task automatic test_invalid_reduction();
        set_op(1, 1, 2, 0, 0, 0, 0, 1, 0, 0);
        step();
        set_op(15, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        n_cmp++;
        if (ifa.out !== 8'h00 || ifa.err !== 1'b1 || ifb.err !== 1'b1) begin
            n_fail++; $display("FAIL red_invalid got out=%h err=%b/%b want 00/1", ifa.out, ifa.err, ifb.err);
        end
        idle();
        step();
        n_cmp++;
        if (ifa.out !== 8'h03 || ifa.leds !== 16'h0000) begin
            n_fail++; $display("FAIL after_invalid got out=%h leds=%h want 03/0000", ifa.out, ifa.leds);
        end
    endtask

    task automatic test_reset_midflight();
        set_op(3, 4, 2, 0, 0, 0, 0, 0, 0, 0);
        step();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        n_cmp++;
        if (ifa.out_valid !== 1'b0 || ifa.out !== 8'h00 || ifb.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got out=%h ov=%b/%b want 00/0", ifa.out, ifa.out_valid, ifb.out_valid);
        end
        set_op(3, 5, 3, 0, 0, 0, 0, 0, 0, 0);
        step();
        idle();
        step();
        n_cmp++;
        if (ifa.out !== 8'h0F || ifa.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL post_reset got out=%h ov=%b want 0f/1", ifa.out, ifa.out_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                set_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7),
                       $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            end else begin
                idle();
            end
            step();
            n_cmp++;
            if (got(0) !== expv(0)) begin
                n_fail++; $display("FAIL rand_a cycle %0d got %h want %h", n, got(0), expv(0));
            end
            n_cmp++;
            if (got(1) !== expv(1)) begin
                n_fail++; $display("FAIL rand_b cycle %0d got %h want %h", n, got(1), expv(1));
            end
        end
        idle();
    endtask

    initial begin
        prev.v = 1'b0;
        rst = 1'b0;
        idle();
        test_reset();
        test_add();
        test_back_to_back();
        test_reduction_priority();
        test_invalid_blink();
        test_invalid_reduction();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
